// File: rtl/uart_autobaud.sv
// Auto-baud controller: measures one 0x55 sync character on rx and publishes the
// clocks-per-oversample-tick divisor. Optional macro UART_AUTOBAUD_GLITCH_FILTER_EN.
module uart_autobaud #(
    parameter int OVERSAMPLE  = 16,
    parameter int CNT_W       = 24,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 163,
    parameter int MIN_DIV     = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx,
    input  logic             arm,
    output logic [DIV_W-1:0] divisor,
    output logic             div_update,
    output logic             locked,
    output logic             busy,
    output logic             err
);

    // Edge 1 to edge 5 spans 8 bit times, each bit is OVERSAMPLE ticks.
    localparam int SHIFT = 3 + $clog2(OVERSAMPLE);
    localparam int QW    = CNT_W + 1;
    localparam int CW    = (QW > DIV_W) ? QW : DIV_W;

    localparam logic [QW-1:0]    ROUND_ADD   = QW'(1) << (SHIFT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CW-1:0]    DIV_MIN_C   = CW'(MIN_DIV);
    localparam logic [CW-1:0]    DIV_MAX_C   = CW'({DIV_W{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_WAIT_START,
        S_MEASURE,
        S_CALC,
        S_LOCKED
    } state_e;

    // ---------------------------------------------------------------- front end
    logic sync1_q, sync1_d;
    logic rx_s_q, rx_s_d;
    logic line;
    logic line_q, line_d;
    logic fall_q, fall_d;

`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
    logic h1_q, h1_d;
    logic h2_q, h2_d;

    // Majority of three consecutive samples: a lone one-cycle pulse never wins.
    assign line = (rx_s_q & h1_q) | (rx_s_q & h2_q) | (h1_q & h2_q);

    always_comb begin
        h1_d = rx_s_q;
        h2_d = h1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h1_q <= 1'b1;
            h2_q <= 1'b1;
        end else begin
            h1_q <= h1_d;
            h2_q <= h2_d;
        end
    end
`else
    assign line = rx_s_q;
`endif

    always_comb begin
        sync1_d = rx;
        rx_s_d  = sync1_q;
        line_d  = line;
        fall_d  = line_q & ~line;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            line_q  <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync1_q <= sync1_d;
            rx_s_q  <= rx_s_d;
            line_q  <= line_d;
            fall_q  <= fall_d;
        end
    end

    // ---------------------------------------------------------------- measurement FSM
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         edges_q, edges_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [DIV_W-1:0]   divisor_q, divisor_d;
    logic               div_update_q, div_update_d;
    logic               locked_q, locked_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [QW-1:0]      q_sum;
    logic [QW-1:0]      q;
    logic [CW-1:0]      q_wide;
    logic               q_ok;

    // Round half up; CNT_W+1 bits hold the sum without overflow.
    assign q_sum  = QW'(period_q) + ROUND_ADD;
    assign q      = q_sum >> SHIFT;
    assign q_wide = CW'(q);
    assign q_ok   = (q_wide >= DIV_MIN_C) && (q_wide <= DIV_MAX_C);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latches.
        state_d      = state_q;
        cnt_d        = cnt_q;
        edges_d      = edges_q;
        period_d     = period_q;
        divisor_d    = divisor_q;
        div_update_d = 1'b0;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_WAIT_IDLE;
                    err_d   = 1'b0;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s_q) state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (fall_q) begin
                    state_d = S_MEASURE;
                    cnt_d   = CNT_W'(1);
                    edges_d = 3'd1;
                end
            end
            S_MEASURE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fall_q && edges_q == 3'd4) begin
                    state_d  = S_CALC;
                    edges_d  = 3'd5;
                    period_d = cnt_q;
                end else if (cnt_q >= TIMEOUT_CNT) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (fall_q) begin
                    edges_d = edges_q + 3'd1;
                end
            end
            S_CALC: begin
                if (q_ok) begin
                    state_d      = S_LOCKED;
                    divisor_d    = DIV_W'(q);
                    div_update_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_LOCKED: begin
                if (arm) begin
                    state_d = S_WAIT_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        locked_d = (state_d == S_LOCKED);
        busy_d   = state_d inside {S_WAIT_IDLE, S_WAIT_START, S_MEASURE, S_CALC};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            edges_q      <= '0;
            period_q     <= '0;
            divisor_q    <= DIV_W'(DEFAULT_DIV);
            div_update_q <= 1'b0;
            locked_q     <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            edges_q      <= edges_d;
            period_q     <= period_d;
            divisor_q    <= divisor_d;
            div_update_q <= div_update_d;
            locked_q     <= locked_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign divisor    = divisor_q;
    assign div_update = div_update_q;
    assign locked     = locked_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: table of sync-character rates plus
// hand-written timeout, reset-abort and glitch sequences.
module tb_uart_autobaud;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx, arm;
    logic [15:0] divisor;
    logic        div_update, locked, busy, err;

    logic        rx2, arm2;
    logic [15:0] divisor2;
    logic        div_update2, locked2, busy2, err2;

    always #5 clk = ~clk;

    uart_autobaud u_dut (
        .clk(clk), .reset_n(reset_n), .rx(rx), .arm(arm),
        .divisor(divisor), .div_update(div_update),
        .locked(locked), .busy(busy), .err(err)
    );

    // Short counter instance used only for the timeout sequence.
    uart_autobaud #(.CNT_W(12)) u_dut_short (
        .clk(clk), .reset_n(reset_n), .rx(rx2), .arm(arm2),
        .divisor(divisor2), .div_update(div_update2),
        .locked(locked2), .busy(busy2), .err(err2)
    );

`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
    localparam int  FILT_LAT = 1;
    localparam logic GLITCH  = 1'b1;
`else
    localparam int  FILT_LAT = 0;
    localparam logic GLITCH  = 1'b0;
`endif
    // Posedges from driving the rx edge to the registered result.
    localparam int LOCK_LAT    = 5 + FILT_LAT;
    localparam int TIMEOUT_LAT = 4098 + FILT_LAT;

    typedef struct {
        int          bit_clks;
        logic        mid_arm;
        logic        glitch;
        logic [15:0] exp_div;
        logic        exp_lock;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] e_div;
        logic        e_lock;
        logic        e_err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_err     = 0;
    int   cycle_cnt = 0;
    int   e5_cycle  = 0;
    int   n_done    = 0;
    logic err_prev  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard side: pops one expectation per lock pulse or new error.
    always @(posedge clk) begin
        exp_t e;
        cycle_cnt++;
        #1;
        if (div_update || (err && !err_prev)) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_unexpected: got div=%0d err=%0d expected no result", divisor, err);
            end else begin
                e = sb_q.pop_front();
                check("sb_divisor", divisor, e.e_div);
                check("sb_locked", locked, e.e_lock);
                check("sb_err", err, e.e_err);
                check("sb_busy", busy, 0);
                if (div_update) check("lock_latency", cycle_cnt - e5_cycle, LOCK_LAT);
            end
            n_done++;
        end
        err_prev = err;
    end

    task automatic do_arm();
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
    endtask

    task automatic send_bits(input int bit_clks, input int n_bits, input logic mid_arm);
        logic [9:0] frame;
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < n_bits; i++) begin
            for (int j = 0; j < bit_clks; j++) begin
                @(negedge clk);
                if (j == 0) begin
                    rx = frame[i];
                    if (i == 8) e5_cycle = cycle_cnt;
                end
                arm = mid_arm && (i == 4) && (j == 0);
            end
        end
        @(negedge clk);
        arm = 1'b0;
        rx  = 1'b1;
    endtask

    task automatic run_case(input vec_t v);
        int target;
        do_arm();
        check("arm_busy", busy, 1);
        check("arm_locked", locked, 0);
        check("arm_err", err, 0);
        if (v.glitch) begin
            repeat (5) @(negedge clk);
            rx = 1'b0;
            @(negedge clk) rx = 1'b1;
            repeat (20) @(negedge clk);
            check("glitch_busy", busy, 1);
            check("glitch_locked", locked, 0);
        end
        target = n_done + 1;
        sb_q.push_back('{e_div: v.exp_div, e_lock: v.exp_lock, e_err: v.exp_err});
        send_bits(v.bit_clks, 10, v.mid_arm);
        for (int k = 0; k < 200 && n_done < target; k++) @(negedge clk);
        check("case_done", n_done >= target, 1);
        if (n_done < target) sb_q.delete();
        check("post_locked", locked, v.exp_lock);
        check("post_err", err, v.exp_err);
        check("post_busy", busy, 0);
        check("post_div_update", div_update, 0);
    endtask

    vec_t vecs[3];
    vec_t post_vec;

    initial begin
        int start;
        vecs[0] = '{bit_clks: 2604, mid_arm: 1'b0, glitch: 1'b0, exp_div: 16'd163, exp_lock: 1'b1, exp_err: 1'b0};
        vecs[1] = '{bit_clks: 434,  mid_arm: 1'b1, glitch: 1'b0, exp_div: 16'd27,  exp_lock: 1'b1, exp_err: 1'b0};
        vecs[2] = '{bit_clks: 8,    mid_arm: 1'b0, glitch: 1'b0, exp_div: 16'd27,  exp_lock: 1'b0, exp_err: 1'b1};
        post_vec = '{bit_clks: 2604, mid_arm: 1'b0, glitch: GLITCH, exp_div: 16'd163, exp_lock: 1'b1, exp_err: 1'b0};

        reset_n = 1'b0;
        rx = 1'b1; arm = 1'b0;
        rx2 = 1'b1; arm2 = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_divisor", divisor, 163);
        check("rst_locked", locked, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_div_update", div_update, 0);

        // rx activity without arm must not start anything.
        for (int i = 0; i < 40; i++) @(negedge clk) rx = $urandom_range(0, 1);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_locked", locked, 0);
        check("idle_divisor", divisor, 163);

        // Timeout on the short-counter instance: start bit only.
        @(negedge clk) arm2 = 1'b1;
        @(negedge clk) arm2 = 1'b0;
        check("to_arm_busy", busy2, 1);
        repeat (3) @(negedge clk);
        rx2 = 1'b0;
        start = cycle_cnt;
        repeat (10) @(negedge clk);
        rx2 = 1'b1;
        for (int k = 0; k < 5000 && !err2; k++) @(negedge clk);
        check("to_err", err2, 1);
        check("to_latency", cycle_cnt - start, TIMEOUT_LAT);
        check("to_busy", busy2, 0);
        check("to_locked", locked2, 0);
        check("to_divisor", divisor2, 163);

        for (int i = 0; i < 3; i++) run_case(vecs[i]);

        // Abort mid-measurement after edge 3; accepted arm also clears err.
        do_arm();
        check("abort_arm_err", err, 0);
        send_bits(2604, 4, 1'b0);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check("abort_divisor", divisor, 163);
        check("abort_locked", locked, 0);
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        repeat (3) @(negedge clk);
        rx = 1'b1;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_idle_busy", busy, 0);

        run_case(post_vec);
        check("final_divisor", divisor, 163);
        check("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
